// File: rtl/aq_vlsu_seg_xpose_pkg.sv
// ---------------------------------------------------------------------------
// aq_vlsu_seg_xpose_pkg
// Shared types for the segment transpose buffer:
//   - element width encodings (cfg_ew)
//   - FSM state encodings
//   - latched group configuration record
// ---------------------------------------------------------------------------
package aq_vlsu_seg_xpose_pkg;

  typedef enum logic [1:0] {
    EW_BYTE  = 2'b00,
    EW_HALF  = 2'b01,
    EW_WORD  = 2'b10,
    EW_DWORD = 2'b11
  } ew_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Group configuration, captured on the first input beat of a group.
  typedef struct packed {
    logic       st;
    logic [2:0] nf;
    ew_e        ew;
  } cfg_t;

endpackage

// File: rtl/aq_vlsu_seg_xpose_idx.sv
// ---------------------------------------------------------------------------
// aq_vlsu_seg_xpose_idx
// Combinational byte-address generator for one side (write or read) of the
// transpose buffer. For every byte lane of a beat it returns the flat byte
// address in the buffer where that byte lives.
//
// The buffer is a flat array of elements, element k occupying bytes
// [k*EB, k*EB+EB-1] (EB = element bytes). Two orderings exist:
//   memory order : k = beat*EPB + slot
//   field order  : k = slot*NF  + beat
// Load writes memory order and reads field order; store does the reverse,
// so the ordering is simply st XOR RD_SIDE.
//
// Ports:
//   st    in  direction (0 load, 1 store)
//   nf    in  field count minus 1
//   ew    in  element width code
//   beat  in  beat index within the group
//   addr  out per byte lane, flat buffer byte address
// ---------------------------------------------------------------------------
module aq_vlsu_seg_xpose_idx
  import aq_vlsu_seg_xpose_pkg::*;
#(
  parameter int DATAW   = 64,
  parameter int NF_MAX  = 8,
  parameter bit RD_SIDE = 1'b0
) (
  input  logic                                            st,
  input  logic [2:0]                                      nf,
  input  logic [1:0]                                      ew,
  input  logic [2:0]                                      beat,
  output logic [DATAW/8-1:0][$clog2(NF_MAX*DATAW/8)-1:0]  addr
);

  localparam int PB = DATAW / 8;
  localparam int AW = $clog2(NF_MAX * PB);

  logic field_order;
  assign field_order = st ^ RD_SIDE;

  always_comb begin
    int s;
    int j;
    int k;
    int epb;
    int nf_n;
    int eb_m;
    addr = '0;
    s    = 0;
    j    = 0;
    k    = 0;
    epb  = PB >> ew;
    nf_n = int'(nf) + 1;
    eb_m = (1 << ew) - 1;
    for (int p = 0; p < PB; p++) begin
      s = p >> ew;
      j = p & eb_m;
      if (field_order) k = s * nf_n + int'(beat);
      else             k = int'(beat) * epb + s;
      addr[p] = AW'((k << ew) | j);
    end
  end

endmodule

// File: rtl/aq_vlsu_seg_xpose.sv
// ---------------------------------------------------------------------------
// aq_vlsu_seg_xpose
// Segment transpose buffer for the vector LSU. Collects NF beats of a
// vlseg/vsseg group and emits them reordered between memory order
// (fields interleaved per element) and field order (one field per beat).
//
// Ports:
//   cpuclk    in   clock
//   cpurst_b  in   async active-low reset
//   flush     in   synchronous abort of the current group
//   in_vld    in   input beat valid
//   in_rdy    out  buffer accepts an input beat (state only)
//   in_data   in   input beat
//   cfg_st    in   0 load (memory->field), 1 store (field->memory)
//   cfg_nf    in   field count minus 1
//   cfg_ew    in   element width code (8/16/32/64 bit)
//   out_vld   out  output beat valid
//   out_rdy   in   consumer accepts output beat
//   out_data  out  output beat
//   out_idx   out  beat index within the group
//   out_last  out  final beat of the group
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | empty; first beat latches cfg and is written as beat 0
// ST_FILL  | collecting beats 1..NF-1
// ST_DRAIN | emitting NF transposed beats, input blocked
// ---------------------------------------------------------------------------
module aq_vlsu_seg_xpose
  import aq_vlsu_seg_xpose_pkg::*;
#(
  parameter int DATAW  = 64,
  parameter int NF_MAX = 8
) (
  input  logic             cpuclk,
  input  logic             cpurst_b,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DATAW-1:0] in_data,
  input  logic             cfg_st,
  input  logic [2:0]       cfg_nf,
  input  logic [1:0]       cfg_ew,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DATAW-1:0] out_data,
  output logic [2:0]       out_idx,
  output logic             out_last
);

  localparam int PB  = DATAW / 8;
  localparam int NBB = NF_MAX * PB;
  localparam int AW  = $clog2(NBB);

  state_e     state_q, state_d;
  logic [2:0] in_cnt_q, in_cnt_d;
  logic [2:0] out_cnt_q, out_cnt_d;
  cfg_t       cfg_q, cfg_wr;
  logic       cfg_ld;
  logic       wr_en;

  logic [7:0]             mem_q [NBB];
  logic [PB-1:0][AW-1:0]  wr_addr;
  logic [PB-1:0][AW-1:0]  rd_addr;

  // The first beat is written in the same cycle cfg is captured, so the
  // write side must see the live cfg inputs while idle.
  always_comb begin
    cfg_wr = cfg_q;
    if (state_q == ST_IDLE) begin
      cfg_wr.st = cfg_st;
      cfg_wr.nf = cfg_nf;
      cfg_wr.ew = ew_e'(cfg_ew);
    end
  end

  aq_vlsu_seg_xpose_idx #(
    .DATAW   (DATAW),
    .NF_MAX  (NF_MAX),
    .RD_SIDE (1'b0)
  ) u_wr_idx (
    .st   (cfg_wr.st),
    .nf   (cfg_wr.nf),
    .ew   (cfg_wr.ew),
    .beat (in_cnt_q),
    .addr (wr_addr)
  );

  aq_vlsu_seg_xpose_idx #(
    .DATAW   (DATAW),
    .NF_MAX  (NF_MAX),
    .RD_SIDE (1'b1)
  ) u_rd_idx (
    .st   (cfg_q.st),
    .nf   (cfg_q.nf),
    .ew   (cfg_q.ew),
    .beat (out_cnt_q),
    .addr (rd_addr)
  );

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      if (cfg_ld) cfg_q <= cfg_wr;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    cfg_ld    = 1'b0;
    wr_en     = 1'b0;
    in_rdy    = 1'b0;
    out_vld   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          cfg_ld = 1'b1;
          wr_en  = 1'b1;
          if (cfg_nf == 3'd0) begin
            state_d   = ST_DRAIN;
            in_cnt_d  = '0;
            out_cnt_d = '0;
          end else begin
            state_d  = ST_FILL;
            in_cnt_d = 3'd1;
          end
        end
      end
      ST_FILL: begin
        in_rdy = 1'b1;
        if (in_vld) begin
          wr_en = 1'b1;
          if (in_cnt_q == cfg_q.nf) begin
            state_d   = ST_DRAIN;
            in_cnt_d  = '0;
            out_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + 3'd1;
          end
        end
      end
      ST_DRAIN: begin
        out_vld = 1'b1;
        if (out_rdy) begin
          if (out_cnt_q == cfg_q.nf) begin
            state_d   = ST_IDLE;
            out_cnt_d = '0;
          end else begin
            out_cnt_d = out_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush outranks any handshake in the same cycle; buffer stays stale.
    if (flush) begin
      state_d   = ST_IDLE;
      in_cnt_d  = '0;
      out_cnt_d = '0;
      cfg_ld    = 1'b0;
      wr_en     = 1'b0;
    end
  end

  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int q = 0; q < NBB; q++) mem_q[q] <= '0;
    end else if (wr_en) begin
      for (int p = 0; p < PB; p++) mem_q[wr_addr[p]] <= in_data[p*8 +: 8];
    end
  end

  always_comb begin
    out_data = '0;
    for (int p = 0; p < PB; p++) out_data[p*8 +: 8] = mem_q[rd_addr[p]];
  end

  assign out_idx  = out_cnt_q;
  assign out_last = out_vld & (out_cnt_q == cfg_q.nf);

endmodule
